// File: rtl/mil1553_pkg.sv
// Shared types and default timing for the MIL-STD-1553 transmit scheduler.
// Imported by mil1553_tx_sched and its bench.
package mil1553_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } sched_state_e;

    localparam logic SYNC_CMD  = 1'b1;
    localparam logic SYNC_DATA = 1'b0;

    localparam int GAP_CYCLES_DEF   = 200;
    localparam int WORD_TIMEOUT_DEF = 1000;

    // The timer counts down to zero inclusive, so N gap cycles need a load of N-1.
    // A zero gap still costs one cycle.
    function automatic int gap_load(input int gap_cycles);
        return (gap_cycles > 1) ? gap_cycles - 1 : 0;
    endfunction

endpackage

// File: rtl/mil1553_sched_timer.sv
// Loadable, saturating down-counter with a done flag.
// Shared by the inter-message gap and the word timeout, which are never active together.
module mil1553_sched_timer #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [CNTW-1:0] load_val,
    input  logic            dec,
    output logic            done
);

    logic [CNTW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/mil1553_tx_sched.sv
// Grants the single 1553 encoder to requester 0 (APB BC path) or 1 (status path) per message.
// Define MIL1553_SCHED_RR_EN for round-robin tie-breaking; default is fixed priority to requester 1.
module mil1553_tx_sched
    import mil1553_pkg::*;
#(
    parameter int GAP_CYCLES   = GAP_CYCLES_DEF,
    parameter int WORD_TIMEOUT = WORD_TIMEOUT_DEF,
    parameter int CNTW         = 16
) (
    input  logic        APB_CLK,
    input  logic        APB_RESET,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_word,
    input  logic [1:0]  req_sync,
    input  logic [1:0]  req_bus,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ready,
    output logic        enc_valid,
    output logic [15:0] enc_word,
    output logic        enc_sync,
    output logic        enc_bus,
    input  logic        enc_ready,
    output logic        busy,
    output logic        grant_id,
    output logic        abort_pulse,
    output logic        abort_id
);

    localparam logic [CNTW-1:0] TMO_LOAD = CNTW'(WORD_TIMEOUT);
    localparam logic [CNTW-1:0] GAP_LOAD = CNTW'(gap_load(GAP_CYCLES));

    sched_state_e    state_q, state_d;
    logic            grant_id_q, grant_id_d;
    logic            enc_bus_q, enc_bus_d;
    logic            abort_id_q, abort_id_d;

    logic            g_valid, g_sync, g_last, xfer, winner;
    logic [15:0]     g_word;
    logic            tmr_load, tmr_dec, tmr_done;
    logic [CNTW-1:0] tmr_load_val;

    assign g_valid = req_valid[grant_id_q];
    assign g_sync  = req_sync[grant_id_q];
    assign g_last  = req_last[grant_id_q];
    assign g_word  = grant_id_q ? req_word[31:16] : req_word[15:0];
    assign xfer    = (state_q == GRANT) && g_valid && enc_ready;

    // grant_id_q resets to 0, so the first round-robin tie goes to requester 1.
    always_comb begin
`ifdef MIL1553_SCHED_RR_EN
        winner = (&req_valid) ? ~grant_id_q : req_valid[1];
`else
        winner = req_valid[1];
`endif
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        enc_bus_d    = enc_bus_q;
        abort_id_d   = abort_id_q;
        enc_valid    = 1'b0;
        enc_word     = '0;
        enc_sync     = SYNC_DATA;
        req_ready    = '0;
        abort_pulse  = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_id_d   = winner;
                    enc_bus_d    = req_bus[winner];
                    tmr_load     = 1'b1;
                    tmr_load_val = TMO_LOAD;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                enc_valid             = g_valid;
                enc_word              = g_word;
                enc_sync              = g_sync;
                req_ready[grant_id_q] = enc_ready;
                // A transfer beats a timeout firing in the same cycle.
                if (xfer) begin
                    tmr_load = 1'b1;
                    if (g_last) begin
                        tmr_load_val = GAP_LOAD;
                        state_d      = GAP;
                    end else begin
                        tmr_load_val = TMO_LOAD;
                    end
                end else if (tmr_done) begin
                    abort_pulse  = 1'b1;
                    abort_id_d   = grant_id_q;
                    tmr_load     = 1'b1;
                    tmr_load_val = GAP_LOAD;
                    state_d      = GAP;
                end else begin
                    tmr_dec = ~g_valid;
                end
            end
            GAP: begin
                if (tmr_done) begin
                    state_d = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge APB_CLK or posedge APB_RESET) begin
        if (APB_RESET) begin
            state_q    <= IDLE;
            grant_id_q <= 1'b0;
            enc_bus_q  <= 1'b0;
            abort_id_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            enc_bus_q  <= enc_bus_d;
            abort_id_q <= abort_id_d;
        end
    end

    mil1553_sched_timer #(
        .CNTW (CNTW)
    ) u_timer (
        .clk      (APB_CLK),
        .rst      (APB_RESET),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .done     (tmr_done)
    );

    assign busy     = (state_q != IDLE);
    assign grant_id = grant_id_q;
    assign enc_bus  = enc_bus_q;
    assign abort_id = abort_id_q;

endmodule

// File: tb/tb_mil1553_tx_sched.sv
// Directed bench for mil1553_tx_sched with default timing (gap 200, timeout 1000).
module tb_mil1553_tx_sched;
    import mil1553_pkg::*;

    localparam int GAP = GAP_CYCLES_DEF;
    localparam int TMO = WORD_TIMEOUT_DEF;
`ifdef MIL1553_SCHED_RR_EN
    localparam logic TIE2_WINNER = 1'b0;
`else
    localparam logic TIE2_WINNER = 1'b1;
`endif

    logic        APB_CLK = 1'b0;
    logic        APB_RESET;
    logic [1:0]  req_valid, req_sync, req_bus, req_last, req_ready;
    logic [31:0] req_word;
    logic        enc_valid, enc_sync, enc_bus, enc_ready;
    logic [15:0] enc_word;
    logic        busy, grant_id, abort_pulse, abort_id;

    int   checks = 0;
    int   errors = 0;
    int   n;
    logic seen_abort, stall_bad;

    always #5 APB_CLK = ~APB_CLK;

    mil1553_tx_sched dut (
        .APB_CLK     (APB_CLK),
        .APB_RESET   (APB_RESET),
        .req_valid   (req_valid),
        .req_word    (req_word),
        .req_sync    (req_sync),
        .req_bus     (req_bus),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .enc_valid   (enc_valid),
        .enc_word    (enc_word),
        .enc_sync    (enc_sync),
        .enc_bus     (enc_bus),
        .enc_ready   (enc_ready),
        .busy        (busy),
        .grant_id    (grant_id),
        .abort_pulse (abort_pulse),
        .abort_id    (abort_id)
    );

    task automatic step();
        @(posedge APB_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge of the first GAP cycle; leaves at the negedge of the IDLE cycle.
    task automatic wait_gap(input string tag);
        int cnt = 0;
        while (busy === 1'b1 && cnt < 3000) begin
            cnt++;
            step();
            @(negedge APB_CLK);
        end
        chk(tag, cnt, GAP);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        APB_RESET = 1'b1;
        req_valid = '0; req_word = '0; req_sync = '0; req_bus = '0; req_last = '0;
        enc_ready = 1'b1;
        @(negedge APB_CLK);
        chk("reset_outs", {req_ready, enc_valid, enc_word, enc_sync, enc_bus, busy,
                           grant_id, abort_pulse, abort_id}, 32'h0);
        step(); step();
        APB_RESET = 1'b0;

        // Requester 0 three-word message on bus 1
        step();
        req_valid = 2'b01; req_word[15:0] = 16'h1C22; req_sync = 2'b01; req_bus = 2'b01; req_last = 2'b00;
        @(negedge APB_CLK);
        chk("t1_idle", {busy, enc_valid}, 32'h0);
        step(); @(negedge APB_CLK);
        chk("t1_w0", {grant_id, enc_bus, enc_sync, req_ready, enc_valid, enc_word},
            {1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 16'h1C22});
        step();
        req_word[15:0] = 16'hAAAA; req_sync = 2'b00;
        @(negedge APB_CLK);
        chk("t1_w1", {enc_valid, enc_sync, enc_word}, {1'b1, 1'b0, 16'hAAAA});
        step();
        req_word[15:0] = 16'h5555; req_last = 2'b01;
        @(negedge APB_CLK);
        chk("t1_w2", {busy, enc_valid, enc_word}, {1'b1, 1'b1, 16'h5555});

        // Both requesters raise valid during the gap: held off, then a tie in IDLE
        step();
        req_valid = 2'b11; req_word = {16'h8001, 16'h1234}; req_sync = 2'b11;
        req_bus = 2'b01; req_last = 2'b01;
        @(negedge APB_CLK);
        chk("t1_gap_holdoff", {busy, enc_valid, req_ready}, {1'b1, 1'b0, 2'b00});
        wait_gap("t1_gap_len");
        chk("t2_idle", {busy, enc_valid, req_ready}, 32'h0);
        step(); @(negedge APB_CLK);
        chk("t2_tie_grant", {grant_id, enc_bus, enc_valid, req_ready, enc_word},
            {1'b1, 1'b0, 1'b1, 2'b10, 16'h8001});
        step();
        req_word[31:16] = 16'h0042; req_sync[1] = 1'b0; req_last[1] = 1'b1;
        @(negedge APB_CLK);
        chk("t2_r1_last", {grant_id, req_ready, enc_sync, enc_word}, {1'b1, 2'b10, 1'b0, 16'h0042});

        // Requester 1 re-raises a single-word message while requester 0 still waits
        step();
        req_word[31:16] = 16'h9999; req_sync[1] = 1'b1; req_last = 2'b11;
        @(negedge APB_CLK);
        wait_gap("t2_gap_len");
        step(); @(negedge APB_CLK);
        chk("t2_tie2_grant", grant_id, TIE2_WINNER);
        chk("t2_tie2_word", enc_word, TIE2_WINNER ? 32'h9999 : 32'h1234);
        step();
        req_valid[TIE2_WINNER] = 1'b0;
        @(negedge APB_CLK);
        wait_gap("t2_gap2_len");
        step(); @(negedge APB_CLK);
        chk("t2_other_grant", {grant_id, enc_valid, enc_bus, enc_word},
            {~TIE2_WINNER, 1'b1, TIE2_WINNER, TIE2_WINNER ? 16'h1234 : 16'h9999});
        step();
        req_valid = 2'b00; req_last = 2'b00;
        @(negedge APB_CLK);
        wait_gap("t2_gap3_len");

        // Requester 0 stalls after its first word
        step();
        req_valid = 2'b01; req_word[15:0] = 16'h0001; req_bus = 2'b00; req_last = 2'b00;
        @(negedge APB_CLK);
        step(); @(negedge APB_CLK);
        chk("t3_first", {enc_valid, grant_id, abort_pulse}, {1'b1, 1'b0, 1'b0});
        step();
        req_valid = 2'b00;
        @(negedge APB_CLK);
        n = 1;
        while (abort_pulse !== 1'b1 && n < TMO + 100) begin
            step(); @(negedge APB_CLK);
            n++;
        end
        chk("t3_abort_lat", n, TMO + 1);
        chk("t3_abort_state", {busy, enc_valid}, {1'b1, 1'b0});
        step(); @(negedge APB_CLK);
        chk("t3_abort_after", {abort_pulse, abort_id, busy}, {1'b0, 1'b0, 1'b1});
        wait_gap("t3_gap_len");

        // Requester 1 stalls after its first word
        step();
        req_valid = 2'b10; req_word[31:16] = 16'h0002; req_bus = 2'b10;
        @(negedge APB_CLK);
        step(); @(negedge APB_CLK);
        chk("t3b_first", {enc_valid, grant_id, enc_bus}, {1'b1, 1'b1, 1'b1});
        step();
        req_valid = 2'b00;
        @(negedge APB_CLK);
        n = 1;
        while (abort_pulse !== 1'b1 && n < TMO + 100) begin
            step(); @(negedge APB_CLK);
            n++;
        end
        chk("t3b_abort_lat", n, TMO + 1);
        step(); @(negedge APB_CLK);
        chk("t3b_abort_id", {abort_pulse, abort_id}, {1'b0, 1'b1});
        wait_gap("t3b_gap_len");

        // Encoder back-pressure for 5000 cycles with req_bus toggled mid-message
        step();
        req_valid = 2'b01; req_word[15:0] = 16'h0101; req_bus = 2'b00; req_sync = 2'b01; req_last = 2'b00;
        @(negedge APB_CLK);
        step(); @(negedge APB_CLK);
        chk("t4_w0", {enc_valid, enc_bus, enc_word}, {1'b1, 1'b0, 16'h0101});
        step();
        req_word[15:0] = 16'h0202; req_sync = 2'b00; enc_ready = 1'b0; req_bus = 2'b01;
        seen_abort = 1'b0; stall_bad = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge APB_CLK);
            if (abort_pulse === 1'b1) seen_abort = 1'b1;
            if (enc_valid !== 1'b1 || enc_word !== 16'h0202 || req_ready !== 2'b00) stall_bad = 1'b1;
            step();
        end
        chk("t4_no_abort", seen_abort, 1'b0);
        chk("t4_stall_hold", stall_bad, 1'b0);
        enc_ready = 1'b1;
        @(negedge APB_CLK);
        chk("t4_resume", {enc_valid, req_ready, enc_bus, enc_word}, {1'b1, 2'b01, 1'b0, 16'h0202});
        step();
        req_word[15:0] = 16'h0303; req_last = 2'b01;
        @(negedge APB_CLK);
        chk("t4_last", {enc_valid, enc_bus, enc_word}, {1'b1, 1'b0, 16'h0303});
        step();
        req_valid = 2'b00; req_last = 2'b00;
        @(negedge APB_CLK);
        wait_gap("t4_gap_len");

        // Next message picks up the new bus
        step();
        req_valid = 2'b01; req_word[15:0] = 16'h0404; req_last = 2'b01;
        @(negedge APB_CLK);
        step(); @(negedge APB_CLK);
        chk("t5_new_bus", {enc_valid, enc_bus, enc_word}, {1'b1, 1'b1, 16'h0404});
        step();
        req_valid = 2'b00; req_last = 2'b00;
        @(negedge APB_CLK);
        wait_gap("t5_gap_len");

        // Reset in the middle of a GRANT
        step();
        req_valid = 2'b10; req_word[31:16] = 16'h7777; req_bus = 2'b10; req_sync = 2'b10; req_last = 2'b10;
        @(negedge APB_CLK);
        step(); @(negedge APB_CLK);
        chk("t6_pre", {enc_valid, grant_id, enc_bus, busy, abort_id}, 32'h1F);
        #1 APB_RESET = 1'b1;
        #1;
        chk("t6_rst_outs", {req_ready, enc_valid, enc_word, enc_sync, enc_bus, busy,
                            grant_id, abort_pulse, abort_id}, 32'h0);
        step(); step();
        APB_RESET = 1'b0;
        @(negedge APB_CLK);
        chk("t6_post_idle", {busy, enc_valid}, 32'h0);
        step(); @(negedge APB_CLK);
        chk("t6_regrant", {enc_valid, grant_id, enc_bus, enc_sync, enc_word},
            {1'b1, 1'b1, 1'b1, 1'b1, 16'h7777});
        step();
        req_valid = 2'b00; req_last = 2'b00;
        @(negedge APB_CLK);
        wait_gap("t6_gap_len");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
